// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester-side and memory-side bundle for mem_port_arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int BE_W = DATA_W / 8;
    localparam int ID_W = $clog2(N_PORTS);

    logic [N_PORTS-1:0]        req_valid;
    logic [N_PORTS*ADDR_W-1:0] req_addr;
    logic [N_PORTS*DATA_W-1:0] req_wdata;
    logic [N_PORTS*BE_W-1:0]   req_byte_enable;
    logic [N_PORTS-1:0]        req_flash;
    logic [N_PORTS-1:0]        req_ready;
    logic [DATA_W-1:0]         req_rdata;
    logic [N_PORTS-1:0]        req_flash_done;

    logic                      mem_valid;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [BE_W-1:0]           mem_byte_enable;
    logic                      mem_flash;
    logic                      mem_ready;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      mem_flash_done;
    logic [ID_W-1:0]           grant_id;

    // Arbiter side: consumes requests, drives the downstream port.
    modport master (
        input  req_valid, req_addr, req_wdata, req_byte_enable, req_flash,
        output req_ready, req_rdata, req_flash_done,
        output mem_valid, mem_addr, mem_wdata, mem_byte_enable, mem_flash,
        input  mem_ready, mem_rdata, mem_flash_done,
        output grant_id
    );

    // Environment side: requesters plus the downstream memory.
    modport slave (
        output req_valid, req_addr, req_wdata, req_byte_enable, req_flash,
        input  req_ready, req_rdata, req_flash_done,
        input  mem_valid, mem_addr, mem_wdata, mem_byte_enable, mem_flash,
        output mem_ready, mem_rdata, mem_flash_done,
        input  grant_id
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one memory port among N_PORTS
//               requesters; flush requests take precedence over accesses.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_port_arbiter_if.master bus
);
    localparam int BE_W = DATA_W / 8;
    localparam int ID_W = $clog2(N_PORTS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_FLUSH  = 3'd2,
        S_RESP   = 3'd3,
        S_FDONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_last_grant;
    logic [ID_W-1:0]     r_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic [DATA_W-1:0]   r_rdata;

    logic [ID_W-1:0]     w_rr_idx;
    logic [ID_W-1:0]     w_fl_idx;
    logic                w_take_flush;
    logic                w_take_access;
    logic                w_capture_rdata;
    logic [N_PORTS-1:0]  w_grant_oh;

    logic [ADDR_W-1:0]   w_addr_arr [N_PORTS];
    logic [DATA_W-1:0]   w_wdata_arr[N_PORTS];
    logic [BE_W-1:0]     w_be_arr   [N_PORTS];

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
        assign w_be_arr[gi]    = bus.req_byte_enable[gi*BE_W +: BE_W];
    end

    // Walk downward so the port closest after r_last_grant is assigned last.
    always_comb begin
        int v_idx;
        v_idx    = 0;
        w_rr_idx = '0;
        for (int i = N_PORTS; i >= 1; i--) begin
            v_idx = (int'(r_last_grant) + i) % N_PORTS;
            if (bus.req_valid[ID_W'(v_idx)]) begin
                w_rr_idx = ID_W'(v_idx);
            end
        end
    end

    always_comb begin
        w_fl_idx = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (bus.req_flash[i]) begin
                w_fl_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_take_flush    = 1'b0;
        w_take_access   = 1'b0;
        w_capture_rdata = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|bus.req_flash) begin
                    w_take_flush = 1'b1;
                    w_state_nxt  = S_FLUSH;
                end else if (|bus.req_valid) begin
                    w_take_access = 1'b1;
                    w_state_nxt   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (bus.mem_ready) begin
                    w_capture_rdata = 1'b1;
                    w_state_nxt     = S_RESP;
                end
            end
            S_FLUSH: begin
                if (bus.mem_flash_done) begin
                    w_state_nxt = S_FDONE;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            S_FDONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= ID_W'(N_PORTS - 1);
            r_grant      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_rdata      <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Flush grants leave the round-robin pointer untouched.
            if (w_take_flush) begin
                r_grant <= w_fl_idx;
            end else if (w_take_access) begin
                r_grant      <= w_rr_idx;
                r_last_grant <= w_rr_idx;
                r_addr       <= w_addr_arr[w_rr_idx];
                r_wdata      <= w_wdata_arr[w_rr_idx];
                r_be         <= w_be_arr[w_rr_idx];
            end
            if (w_capture_rdata) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    assign w_grant_oh          = {{(N_PORTS-1){1'b0}}, 1'b1} << r_grant;
    assign bus.req_ready       = (r_state == S_RESP)  ? w_grant_oh : '0;
    assign bus.req_flash_done  = (r_state == S_FDONE) ? w_grant_oh : '0;
    assign bus.req_rdata       = r_rdata;
    assign bus.mem_valid       = (r_state == S_ACCESS);
    assign bus.mem_flash       = (r_state == S_FLUSH);
    assign bus.mem_addr        = r_addr;
    assign bus.mem_wdata       = r_wdata;
    assign bus.mem_byte_enable = r_be;
    assign bus.grant_id        = r_grant;

endmodule

`default_nettype wire
